// File: rtl/cnn_acc_ci_tm.sv
// Time-multiplexed input-channel accumulator for one CNN output pixel.
// Each accepted beat carries P channel lanes of a KX*KY window. The beat's
// products are reduced into a partial sum (S1), accumulated over NB = CI/P
// beats (S2), then biased, optionally rectified and saturated (S3).
// A single enable stalls the whole pipeline while a result waits downstream.
module cnn_acc_ci_tm #(
  parameter int CI     = 8,
  parameter int P      = 4,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int B_BW   = 16,
  parameter int O_BW   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_soft_reset,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [P*KX*KY*I_F_BW-1:0]  i_in_fmap,
  input  logic [P*KX*KY*W_BW-1:0]    i_cnn_weight,
  input  logic [B_BW-1:0]            i_bias,
  input  logic                       i_relu_en,
  output logic                       o_ot_valid,
  input  logic                       i_ot_ready,
  output logic [O_BW-1:0]            o_ot_acc,
  output logic                       o_ot_sat
);

  localparam int ACC_BW = I_F_BW + W_BW + $clog2(CI * KX * KY) + 1;
  localparam int NB     = CI / P;
  localparam int TAPS   = P * KX * KY;
  localparam int PW     = I_F_BW + W_BW;
  localparam int CW     = (NB > 1) ? $clog2(NB) : 1;
  // One bit of headroom over the wider of accumulator and bias for the bias add.
  localparam int VW     = ((ACC_BW > B_BW) ? ACC_BW : B_BW) + 1;
  localparam logic signed [VW-1:0] O_MAX = VW'((64'sd1 <<< (O_BW - 1)) - 64'sd1);
  localparam logic signed [VW-1:0] O_MIN = VW'(-(64'sd1 <<< (O_BW - 1)));

  // Pipeline state
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [ACC_BW-1:0] s1_psum_q, s1_psum_d;
  logic                     s1_first_q, s1_first_d;
  logic                     s1_last_q, s1_last_d;
  logic [B_BW-1:0]          s1_bias_q, s1_bias_d;
  logic                     s1_relu_q, s1_relu_d;
  logic                     s2_valid_q, s2_valid_d;
  logic signed [ACC_BW-1:0] acc_q, acc_d;
  logic [B_BW-1:0]          bias_q, bias_d;
  logic                     relu_q, relu_d;
  logic                     ot_valid_q, ot_valid_d;
  logic [O_BW-1:0]          ot_acc_q, ot_acc_d;
  logic                     ot_sat_q, ot_sat_d;

  // Combinational helpers
  logic                     en_s;
  logic                     accept_s;
  logic                     first_s;
  logic                     last_s;
  logic signed [PW-1:0]     prod_s;
  logic signed [ACC_BW-1:0] psum_s;
  logic signed [VW-1:0]     v_s;
  logic signed [VW-1:0]     vr_s;
  logic [O_BW-1:0]          sat_val_s;
  logic                     sat_flag_s;

  // A pending result that is not being taken freezes every stage.
  assign en_s       = ~(ot_valid_q & ~i_ot_ready);
  assign o_in_ready = en_s & reset_n & ~i_soft_reset;
  assign accept_s   = i_in_valid & o_in_ready;
  assign first_s    = (cnt_q == CW'(0));
  assign last_s     = (cnt_q == CW'(NB - 1));

  assign o_ot_valid = ot_valid_q;
  assign o_ot_acc   = ot_acc_q;
  assign o_ot_sat   = ot_sat_q;

  // Reduce all lane/tap products of the incoming beat into one signed partial sum.
  always_comb begin
    prod_s = '0;
    psum_s = '0;
    for (int i = 0; i < TAPS; i++) begin
      prod_s = $signed(i_in_fmap[i*I_F_BW +: I_F_BW]) * $signed(i_cnn_weight[i*W_BW +: W_BW]);
      psum_s = psum_s + {{(ACC_BW - PW){prod_s[PW-1]}}, prod_s};
    end
  end

  // Bias add, optional ReLU and clipping to the signed output range.
  always_comb begin
    v_s = {{(VW - ACC_BW){acc_q[ACC_BW-1]}}, acc_q} + {{(VW - B_BW){bias_q[B_BW-1]}}, bias_q};
    if (relu_q && v_s[VW-1]) begin
      vr_s = '0;
    end else begin
      vr_s = v_s;
    end
    if (vr_s > O_MAX) begin
      sat_val_s  = O_MAX[O_BW-1:0];
      sat_flag_s = 1'b1;
    end else if (vr_s < O_MIN) begin
      sat_val_s  = O_MIN[O_BW-1:0];
      sat_flag_s = 1'b1;
    end else begin
      sat_val_s  = vr_s[O_BW-1:0];
      sat_flag_s = 1'b0;
    end
  end

  // Next-state for counter and all three stages; everything holds while stalled.
  always_comb begin
    cnt_d      = cnt_q;
    s1_valid_d = s1_valid_q;
    s1_psum_d  = s1_psum_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_bias_d  = s1_bias_q;
    s1_relu_d  = s1_relu_q;
    s2_valid_d = s2_valid_q;
    acc_d      = acc_q;
    bias_d     = bias_q;
    relu_d     = relu_q;
    ot_valid_d = ot_valid_q;
    ot_acc_d   = ot_acc_q;
    ot_sat_d   = ot_sat_q;
    if (en_s) begin
      // S1: capture the reduced beat with its group position and side-band.
      s1_valid_d = accept_s;
      if (accept_s) begin
        s1_psum_d  = psum_s;
        s1_first_d = first_s;
        s1_last_d  = last_s;
        s1_bias_d  = i_bias;
        s1_relu_d  = i_relu_en;
        cnt_d      = last_s ? CW'(0) : cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
      // S2: restart or extend the group sum; bias/relu come from the first beat only.
      s2_valid_d = s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        acc_d = s1_first_q ? s1_psum_q : acc_q + s1_psum_q;
        if (s1_first_q) begin
          bias_d = s1_bias_q;
          relu_d = s1_relu_q;
        end else begin
          bias_d = bias_q;
          relu_d = relu_q;
        end
      end else begin
        acc_d = acc_q;
      end
      // S3: a finished group replaces the output; otherwise a taken result retires.
      ot_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        ot_acc_d = sat_val_s;
        ot_sat_d = sat_flag_s;
      end else begin
        ot_acc_d = ot_acc_q;
        ot_sat_d = ot_sat_q;
      end
    end else begin
      ot_valid_d = ot_valid_q;
    end
  end

  // State registers with async reset and synchronous soft clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_psum_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bias_q  <= '0;
      s1_relu_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
      bias_q     <= '0;
      relu_q     <= 1'b0;
      ot_valid_q <= 1'b0;
      ot_acc_q   <= '0;
      ot_sat_q   <= 1'b0;
    end else if (i_soft_reset) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_psum_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bias_q  <= '0;
      s1_relu_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
      bias_q     <= '0;
      relu_q     <= 1'b0;
      ot_valid_q <= 1'b0;
      ot_acc_q   <= '0;
      ot_sat_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_psum_q  <= s1_psum_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_bias_q  <= s1_bias_d;
      s1_relu_q  <= s1_relu_d;
      s2_valid_q <= s2_valid_d;
      acc_q      <= acc_d;
      bias_q     <= bias_d;
      relu_q     <= relu_d;
      ot_valid_q <= ot_valid_d;
      ot_acc_q   <= ot_acc_d;
      ot_sat_q   <= ot_sat_d;
    end
  end

endmodule

// File: tb/tb_cnn_acc_ci_tm.sv
// Scoreboard bench for cnn_acc_ci_tm: the driver pushes expected pixel results
// computed from whole groups of beats; a monitor pops them on each output handshake.
module tb_cnn_acc_ci_tm;

  localparam int CI = 8, P = 4, KX = 3, KY = 3;
  localparam int I_F_BW = 8, W_BW = 8, B_BW = 16, O_BW = 16;
  localparam int NB = CI / P;
  localparam int TAPS = P * KX * KY;

  logic clk = 1'b0;
  logic reset_n, i_soft_reset, i_in_valid, o_in_ready;
  logic [TAPS*I_F_BW-1:0] i_in_fmap;
  logic [TAPS*W_BW-1:0]   i_cnn_weight;
  logic [B_BW-1:0] i_bias;
  logic i_relu_en, o_ot_valid, i_ot_ready, o_ot_sat;
  logic [O_BW-1:0] o_ot_acc;

  cnn_acc_ci_tm #(.CI(CI), .P(P), .KX(KX), .KY(KY), .I_F_BW(I_F_BW), .W_BW(W_BW),
                  .B_BW(B_BW), .O_BW(O_BW)) dut (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(i_soft_reset),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_fmap(i_in_fmap), .i_cnn_weight(i_cnn_weight),
    .i_bias(i_bias), .i_relu_en(i_relu_en),
    .o_ot_valid(o_ot_valid), .i_ot_ready(i_ot_ready),
    .o_ot_acc(o_ot_acc), .o_ot_sat(o_ot_sat));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fm[TAPS];
  int wt[TAPS];
  int beat_idx = 0;
  longint grp_sum;
  int grp_bias;
  bit grp_relu;
  int exp_acc_q[$];
  bit exp_sat_q[$];
  bit rand_mode = 1'b0;
  bit hold_pend = 1'b0;
  logic [O_BW-1:0] hold_acc;
  logic hold_sat;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) i_ot_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic fill_const(input int f, input int w);
    for (int i = 0; i < TAPS; i++) begin
      fm[i] = f;
      wt[i] = w;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < TAPS; i++) begin
      fm[i] = int'($urandom_range(0, 255)) - 128;
      wt[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Reference: a group result is the plain sum of every fmap*weight product of
  // all its beats, plus the first beat's bias, rectified if the first beat asked,
  // clipped to the signed 16-bit range.
  task automatic model_beat(input int bias, input bit relu);
    longint s = 0;
    longint v;
    for (int i = 0; i < TAPS; i++) s += longint'(fm[i]) * longint'(wt[i]);
    if (beat_idx == 0) begin
      grp_sum = 0;
      grp_bias = bias;
      grp_relu = relu;
    end
    grp_sum += s;
    if (beat_idx == NB - 1) begin
      v = grp_sum + grp_bias;
      if (grp_relu && v < 0) v = 0;
      if (v > 32767) begin
        exp_acc_q.push_back(32767);
        exp_sat_q.push_back(1'b1);
      end else if (v < -32768) begin
        exp_acc_q.push_back(-32768);
        exp_sat_q.push_back(1'b1);
      end else begin
        exp_acc_q.push_back(int'(v));
        exp_sat_q.push_back(1'b0);
      end
      beat_idx = 0;
    end else begin
      beat_idx++;
    end
  endtask

  task automatic send_beat(input int bias, input bit relu);
    bit acc = 1'b0;
    int n = 0;
    for (int i = 0; i < TAPS; i++) begin
      i_in_fmap[i*I_F_BW +: I_F_BW] = 8'(fm[i]);
      i_cnn_weight[i*W_BW +: W_BW]  = 8'(wt[i]);
    end
    i_bias = 16'(bias);
    i_relu_en = relu;
    i_in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = o_in_ready;
      tick();
      n++;
    end
    if (!acc) chk("beat_accept_timeout", 0, 1);
    else model_beat(bias, relu);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_acc_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_acc_q.size(), 0);
    repeat (2) tick();
  endtask

  // Monitor: pops on each handshake and checks that an untaken result stays put.
  initial begin
    int ea;
    bit es;
    forever begin
      @(negedge clk);
      if (reset_n && !i_soft_reset && o_ot_valid) begin
        if (hold_pend) begin
          chk("hold_acc", longint'($signed(o_ot_acc)), longint'($signed(hold_acc)));
          chk("hold_sat", o_ot_sat, hold_sat);
        end
        if (i_ot_ready) begin
          hold_pend = 1'b0;
          if (exp_acc_q.size() == 0) begin
            chk("unexpected_result", longint'($signed(o_ot_acc)), 99999);
          end else begin
            ea = exp_acc_q.pop_front();
            es = exp_sat_q.pop_front();
            chk("result_acc", longint'($signed(o_ot_acc)), ea);
            chk("result_sat", o_ot_sat, es);
          end
        end else begin
          hold_pend = 1'b1;
          hold_acc = o_ot_acc;
          hold_sat = o_ot_sat;
        end
      end else if (hold_pend) begin
        chk("valid_dropped_before_handshake", o_ot_valid, 1);
        hold_pend = 1'b0;
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    i_soft_reset = 1'b0;
    i_in_valid = 1'b0;
    i_in_fmap = '0;
    i_cnn_weight = '0;
    i_bias = '0;
    i_relu_en = 1'b0;
    i_ot_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", o_in_ready, 0);
    chk("reset_ot_valid", o_ot_valid, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ot_valid", o_ot_valid, 0);
    chk("post_reset_ot_acc", o_ot_acc, 0);
    chk("post_reset_ot_sat", o_ot_sat, 0);
    chk("post_reset_in_ready", o_in_ready, 1);
    tick();

    // Basic group of all ones, with latency to the output.
    fill_const(1, 1);
    send_beat(0, 1'b0);
    send_beat(0, 1'b0);
    i_in_valid = 1'b0;
    @(negedge clk);
    chk("latency_t1_valid", o_ot_valid, 0);
    @(negedge clk);
    chk("latency_t2_valid", o_ot_valid, 0);
    @(negedge clk);
    chk("latency_t3_valid", o_ot_valid, 1);
    chk("basic_acc_72", longint'($signed(o_ot_acc)), 72);
    tick();
    drain();

    // Bias and ReLU, including relu raised on a non-first beat only.
    fill_const(1, -1);
    send_beat(10, 1'b0); send_beat(10, 1'b0);
    send_beat(10, 1'b1); send_beat(10, 1'b1);
    send_beat(10, 1'b0); send_beat(10, 1'b1);
    i_in_valid = 1'b0;
    drain();

    // Saturation at both rails.
    fill_const(127, 127);
    send_beat(0, 1'b0); send_beat(0, 1'b0);
    fill_const(127, -128);
    send_beat(0, 1'b0); send_beat(0, 1'b0);
    i_in_valid = 1'b0;
    drain();

    // Backpressure: the first result is held while more beats are offered.
    i_ot_ready = 1'b0;
    fill_const(1, 1);
    send_beat(0, 1'b0); send_beat(0, 1'b0);
    fork
      begin
        fill_const(1, 2);
        for (int b = 0; b < 4; b++) send_beat(0, 1'b0);
        i_in_valid = 1'b0;
      end
      begin
        repeat (8) @(negedge clk);
        chk("bp_in_ready_low", o_in_ready, 0);
        chk("bp_ot_valid_high", o_ot_valid, 1);
        chk("bp_ot_acc_72", longint'($signed(o_ot_acc)), 72);
        repeat (3) @(negedge clk);
        chk("bp_ot_acc_stable", longint'($signed(o_ot_acc)), 72);
        @(posedge clk);
        #1 i_ot_ready = 1'b1;
      end
    join
    drain();

    // Soft reset in the middle of a group discards the partial sum.
    fill_const(1, 1);
    send_beat(0, 1'b0);
    i_in_valid = 1'b0;
    repeat (3) tick();
    i_soft_reset = 1'b1;
    beat_idx = 0;
    @(negedge clk);
    chk("srst_in_ready_low", o_in_ready, 0);
    tick();
    i_soft_reset = 1'b0;
    fill_const(2, 1);
    send_beat(0, 1'b0); send_beat(0, 1'b0);
    i_in_valid = 1'b0;
    drain();

    // Streaming random groups with random downstream readiness.
    rand_mode = 1'b1;
    for (int g = 0; g < 10; g++) begin
      for (int b = 0; b < NB; b++) begin
        fill_rand();
        send_beat(int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)));
      end
    end
    i_in_valid = 1'b0;
    repeat (20) tick();
    rand_mode = 1'b0;
    i_ot_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
